// File: rtl/fpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fpu_pkg                                                |
// | Description : Shared FP64 field constants, issue-slot kinds and the  |
// |               result record stored in the fpuprod_seq output FIFO.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package fpu_pkg;

   // FP64 layout: sign 63, exponent 62:53 (bias 0x200), mantissa 52:0
   localparam int         SIGN   = 63;
   localparam int         EXP_HI = 62;
   localparam int         EXP_LO = 53;
   localparam int         MANT_W = 53;
   localparam logic [9:0] BIAS   = 10'h200;

   // What a multiplier issue slot produces when its result comes back
   typedef enum logic [1:0] {
      SGL = 2'd0,   // single-length product, pushed on its own
      HI  = 2'd1,   // high half of a double, parked until its LO arrives
      LO  = 2'd2    // low half of a double, pushed together with the HI
   } slot_kind_e;

   // Result record held in the output FIFO (tag is appended separately
   // because its width is a parameter of the instantiating block)
   typedef struct packed {
      logic [63:0] hi;
      logic [63:0] lo;
      logic        dbl;
   } fifo_res_t;

endpackage
`default_nettype wire

// File: rtl/fpuprod_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fpuprod_fifo                                           |
// | Description : DEPTH x W synchronous FIFO with occupancy count.        |
// |               Push and pop may happen in the same cycle, also when   |
// |               full (the popped slot is reused) or empty.             |
// | Ports       : clk, rst (sync, active-low)                            |
// |               push_i/data_i  - write side                            |
// |               pop_i/data_o   - read side, data_o is the head entry   |
// |               count_o        - entries currently held (0..DEPTH)     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module fpuprod_fifo
#(
   parameter int DEPTH = 4,
   parameter int W     = 133
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  logic [W-1:0]               data_i,
   input  logic                       pop_i,
   output logic [W-1:0]               data_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int             AW     = $clog2(DEPTH);
   localparam logic [AW:0]    C_FULL = (AW+1)'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q;
   logic [AW-1:0] rd_q;
   logic [AW:0]   cnt_q;

   logic w_pop;
   logic w_push;

   // A pop frees the head slot in the same edge, so a full FIFO can
   // still take a push when it is also being read.
   assign w_pop  = pop_i && (cnt_q != '0);
   assign w_push = push_i && ((cnt_q != C_FULL) || w_pop);

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (w_push) wr_q <= wr_q + AW'(1);
         if (w_pop)  rd_q <= rd_q + AW'(1);
         cnt_q <= cnt_q + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
   end

   // Storage carries no reset; validity is tracked by cnt_q alone
   always_ff @(posedge clk) begin
      if (w_push) mem_q[wr_q] <= data_i;
   end

   assign data_o  = mem_q[rd_q];
   assign count_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/fpuprod_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fpuprod_seq                                            |
// | Description : Issue/collect sequencer around the fpuprod64 multiplier|
// |               stage. Requests are issued once (single) or twice      |
// |               (double: high half then low half), results are paired  |
// |               and returned in order through a backpressured FIFO.    |
// |               Credits reserve a FIFO slot for every issued request   |
// |               because the multiplier pipeline cannot stall.          |
// | Ports       : clk, rst (sync, active-low)                            |
// |               in_*   - request handshake and operands               |
// |               mul_*  - registered multiplier operands / raw results  |
// |               out_*  - result handshake, head of the output FIFO     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module fpuprod_seq
   import fpu_pkg::*;
#(
   parameter int MUL_LAT = 2,
   parameter int DEPTH   = 4,
   parameter int TAG_W   = 4
) (
   input  logic              clk,
   input  logic              rst,
   // request side
   input  logic              in_vld,
   output logic              in_rdy,
   input  logic [63:0]       in_A,
   input  logic [63:0]       in_B,
   input  logic              in_rnd,
   input  logic              in_dbl,
   input  logic [TAG_W-1:0]  in_tag,
   // multiplier side
   output logic [63:0]       mul_A,
   output logic [63:0]       mul_B,
   output logic              mul_rnd,
   output logic              mul_pookg,
   input  logic [63:0]       mul_res,
   input  logic [63:0]       mul_res2,
   // result side
   output logic              out_vld,
   input  logic              out_rdy,
   output logic [63:0]       out_hi,
   output logic [63:0]       out_lo,
   output logic              out_dbl,
   output logic [TAG_W-1:0]  out_tag,
   output logic              out_ovf
);

   localparam int              CW      = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0]   C_LIMIT = CW'(DEPTH);
   localparam int              FW      = $bits(fifo_res_t) + TAG_W;

   localparam logic [0:0]      S_IDLE  = 1'b0;
   localparam logic [0:0]      S_LO    = 1'b1;

   typedef struct packed {
      logic             vld;
      slot_kind_e       kind;
      logic [TAG_W-1:0] tag;
   } slot_t;

   logic [0:0]       state_q, state_d;
   logic [CW-1:0]    credits_q, credits_d;
   logic             lo_phase;
   logic             w_accept;
   logic             w_pop;

   logic [63:0]      mul_a_q, mul_b_q;
   logic             mul_rnd_q, mul_pookg_q;
   slot_t            iss_q;
   slot_t            sr_q [MUL_LAT];
   slot_t            w_tail;
   logic [63:0]      pend_q;

   logic             w_push;
   fifo_res_t        w_push_res;
   logic [FW-1:0]    w_fifo_out;
   fifo_res_t        w_head_res;
   logic [TAG_W-1:0] w_head_tag;
   logic [CW-1:0]    w_fifo_cnt;

   // ---------------------------------------------------------------
   // FSM: state register / next state / outputs
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (w_accept && in_dbl) state_d = S_LO;
         S_LO:    state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // in_rdy looks only at registered state (and the reset pin), never
   // at out_rdy, so there is no combinational path across the block.
   always_comb begin
      in_rdy   = 1'b0;
      lo_phase = 1'b0;
      case (state_q)
         S_IDLE:  in_rdy   = rst && (credits_q < C_LIMIT);
         S_LO:    lo_phase = 1'b1;
         default: ;
      endcase
   end

   assign w_accept = in_vld && in_rdy;
   assign w_pop    = out_vld && out_rdy;

   // ---------------------------------------------------------------
   // Credits: one per accepted request (a double uses one), returned
   // when its result leaves the FIFO.
   // ---------------------------------------------------------------
   always_comb begin
      credits_d = credits_q + CW'(w_accept) - CW'(w_pop);
   end

   always_ff @(posedge clk) begin
      if (!rst) credits_q <= '0;
      else      credits_q <= credits_d;
   end

   // ---------------------------------------------------------------
   // Issue stage: operand registers plus the slot marker that rides
   // alongside them into the latency shift register.
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         mul_a_q     <= '0;
         mul_b_q     <= '0;
         mul_rnd_q   <= 1'b0;
         mul_pookg_q <= 1'b0;
         iss_q       <= '0;
      end else begin
         iss_q.vld <= 1'b0;
         if (w_accept) begin
            mul_a_q     <= in_A;
            mul_b_q     <= in_B;
            mul_rnd_q   <= in_rnd;
            mul_pookg_q <= 1'b0;
            iss_q.vld   <= 1'b1;
            iss_q.kind  <= in_dbl ? HI : SGL;
            iss_q.tag   <= in_tag;
         end else if (lo_phase) begin
            // operands held from the HI issue; tag is unchanged too
            mul_pookg_q <= 1'b1;
            iss_q.vld   <= 1'b1;
            iss_q.kind  <= LO;
         end
      end
   end

   assign mul_A     = mul_a_q;
   assign mul_B     = mul_b_q;
   assign mul_rnd   = mul_rnd_q;
   assign mul_pookg = mul_pookg_q;

   // The tail entry is the slot whose result is on mul_res/mul_res2
   // during the current cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < MUL_LAT; i++) sr_q[i] <= '0;
      end else begin
         sr_q[0] <= iss_q;
         for (int i = MUL_LAT - 1; i > 0; i--) sr_q[i] <= sr_q[i-1];
      end
   end

   assign w_tail = sr_q[MUL_LAT-1];

   // ---------------------------------------------------------------
   // Result capture. LO slots read only mul_res2: the low mantissa
   // bits of mul_res are not driven in the low-half pass.
   // ---------------------------------------------------------------
   always_comb begin
      w_push     = 1'b0;
      w_push_res = '0;
      if (w_tail.vld) begin
         case (w_tail.kind)
            SGL: begin
               w_push         = 1'b1;
               w_push_res.hi  = mul_res;
            end
            LO: begin
               w_push         = 1'b1;
               w_push_res.hi  = pend_q;
               w_push_res.lo  = mul_res2;
               w_push_res.dbl = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst)                                pend_q <= '0;
      else if (w_tail.vld && w_tail.kind == HI) pend_q <= mul_res;
   end

   // ---------------------------------------------------------------
   // Output FIFO
   // ---------------------------------------------------------------
   fpuprod_fifo #(
      .DEPTH   (DEPTH),
      .W       (FW)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (w_push),
      .data_i  ({w_push_res, w_tail.tag}),
      .pop_i   (w_pop),
      .data_o  (w_fifo_out),
      .count_o (w_fifo_cnt)
   );

   assign {w_head_res, w_head_tag} = w_fifo_out;

   // Outputs are forced to zero whenever nothing valid is presented
   assign out_vld = rst && (w_fifo_cnt != '0);
   assign out_hi  = out_vld ? w_head_res.hi  : '0;
   assign out_lo  = out_vld ? w_head_res.lo  : '0;
   assign out_dbl = out_vld ? w_head_res.dbl : 1'b0;
   assign out_tag = out_vld ? w_head_tag     : '0;
   assign out_ovf = &out_hi[EXP_HI:EXP_LO];

endmodule
`default_nettype wire

// File: tb/tb_fpuprod_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_fpuprod_seq                                         |
// | Description : Self-checking bench for fpuprod_seq with a behavioural |
// |               2-cycle multiplier attached to the mul_* ports.        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_fpuprod_seq;
   import fpu_pkg::*;

   localparam int MUL_LAT = 2;
   localparam int DEPTH   = 4;
   localparam int TAG_W   = 4;

   logic              clk, rst;
   logic              in_vld, in_rdy, in_rnd, in_dbl;
   logic [63:0]       in_A, in_B;
   logic [TAG_W-1:0]  in_tag;
   logic [63:0]       mul_A, mul_B, mul_res, mul_res2;
   logic              mul_rnd, mul_pookg;
   logic              out_vld, out_rdy, out_dbl, out_ovf;
   logic [63:0]       out_hi, out_lo;
   logic [TAG_W-1:0]  out_tag;

   fpuprod_seq #(.MUL_LAT(MUL_LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst),
      .in_vld(in_vld), .in_rdy(in_rdy), .in_A(in_A), .in_B(in_B),
      .in_rnd(in_rnd), .in_dbl(in_dbl), .in_tag(in_tag),
      .mul_A(mul_A), .mul_B(mul_B), .mul_rnd(mul_rnd), .mul_pookg(mul_pookg),
      .mul_res(mul_res), .mul_res2(mul_res2),
      .out_vld(out_vld), .out_rdy(out_rdy), .out_hi(out_hi), .out_lo(out_lo),
      .out_dbl(out_dbl), .out_tag(out_tag), .out_ovf(out_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- multiplier stand-in ----------------
   function automatic logic [9:0] sat10(input int e);
      if (e < 0)    return 10'h000;
      if (e > 1023) return 10'h3FF;
      return 10'(e);
   endfunction

   // Returns {mul_res, mul_res2}; the half not produced in a pass is junk
   function automatic logic [127:0] fmul(input logic [63:0] a, input logic [63:0] b,
                                         input logic rnd, input logic pk);
      logic [MANT_W:0]     sa, sb;
      logic [2*MANT_W+1:0] p;
      logic [2*MANT_W:0]   pn;
      logic [63:0]         hi, lo, r1, r2;
      int                  e;
      logic                s;
      s  = a[SIGN] ^ b[SIGN];
      sa = {1'b1, a[MANT_W-1:0]};
      sb = {1'b1, b[MANT_W-1:0]};
      p  = (2*MANT_W+2)'(sa) * (2*MANT_W+2)'(sb);
      e  = int'(a[EXP_HI:EXP_LO]) + int'(b[EXP_HI:EXP_LO]) - int'(BIAS);
      if (p[2*MANT_W+1]) begin
         pn = p[2*MANT_W+1:1];
         e  = e + 1;
      end else begin
         pn = p[2*MANT_W:0];
      end
      hi = {s, sat10(e), pn[2*MANT_W-1:MANT_W]};
      lo = {s, sat10(e - MANT_W), pn[MANT_W-1:0] ^ MANT_W'(rnd)};
      if (!pk) begin
         r1 = hi;
         r2 = 64'hDEAD_BEEF_DEAD_BEEF;
      end else begin
         r1 = {hi[63:53], 53'h0A_AAAA_AAAA_AAAA};
         r2 = lo;
      end
      return {r1, r2};
   endfunction

   logic [63:0] m1_res, m1_res2, m2_res, m2_res2;
   always @(posedge clk) begin
      {m1_res, m1_res2} <= fmul(mul_A, mul_B, mul_rnd, mul_pookg);
      m2_res  <= m1_res;
      m2_res2 <= m1_res2;
   end
   assign mul_res  = m2_res;
   assign mul_res2 = m2_res2;

   // ---------------- checking infrastructure ----------------
   typedef struct {
      logic [63:0]      hi;
      logic [63:0]      lo;
      logic             dbl;
      logic [TAG_W-1:0] tag;
   } exp_t;

   typedef struct {
      logic [63:0] a, b;
      logic        rnd, dbl;
      logic [3:0]  tag;
      logic [63:0] hi, lo;
      logic        ovf;
   } vec_t;

   exp_t sbq[$];
   int   n_chk = 0, n_pass = 0;
   int   n_acc = 0, n_pop = 0, max_out = 0;

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h required %0h", name, act, req);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One clock of the streaming phases: record the accept, check a pop
   // against the scoreboard, then advance.
   task automatic step();
      exp_t        e;
      logic [127:0] r0, r1;
      if (in_vld && in_rdy) begin
         r0    = fmul(in_A, in_B, in_rnd, 1'b0);
         r1    = fmul(in_A, in_B, in_rnd, 1'b1);
         e.hi  = r0[127:64];
         e.lo  = in_dbl ? r1[63:0] : 64'h0;
         e.dbl = in_dbl;
         e.tag = in_tag;
         sbq.push_back(e);
         n_acc++;
      end
      if (out_vld && out_rdy) begin
         n_pop++;
         if (sbq.size() == 0) begin
            n_chk++;
            $display("FAIL stream_extra: got tag %0h required no output", out_tag);
         end else begin
            e = sbq.pop_front();
            chk("stream", 160'({out_hi, out_lo, out_dbl, out_tag}),
                160'({e.hi, e.lo, e.dbl, e.tag}));
         end
      end
      if (n_acc - n_pop > max_out) max_out = n_acc - n_pop;
      tick();
   endtask

   vec_t        vt [7];
   logic [63:0] opa [6];
   logic [63:0] opb [6];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n, lat, acc0, pop0, issued, prev, cyc, stale;

      //                a                      b                      rnd   dbl   tag   hi                     lo                     ovf
      vt[0] = '{64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b0, 1'b0, 4'h3, 64'h4000_0000_0000_0000, 64'h0,                 1'b0};
      vt[1] = '{64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b0, 1'b1, 4'h7, 64'h4000_0000_0000_0000, 64'h3960_0000_0000_0000, 1'b0};
      vt[2] = '{64'hC000_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b0, 1'b0, 4'h9, 64'hC000_0000_0000_0000, 64'h0,                 1'b0};
      vt[3] = '{64'h4010_0000_0000_0000, 64'h4010_0000_0000_0000, 1'b0, 1'b0, 4'h5, 64'h4024_0000_0000_0000, 64'h0,                 1'b0};
      vt[4] = '{64'h7E00_0000_0000_0000, 64'h7E00_0000_0000_0000, 1'b0, 1'b0, 4'hA, 64'h7FE0_0000_0000_0000, 64'h0,                 1'b1};
      vt[5] = '{64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b1, 1'b1, 4'hF, 64'h4000_0000_0000_0000, 64'h3960_0000_0000_0001, 1'b0};
      vt[6] = '{64'hC010_0000_0000_0000, 64'h4010_0000_0000_0000, 1'b0, 1'b1, 4'h2, 64'hC024_0000_0000_0000, 64'hB980_0000_0000_0000, 1'b0};

      rst = 1'b0; in_vld = 1'b0; in_A = '0; in_B = '0; in_rnd = 1'b0;
      in_dbl = 1'b0; in_tag = '0; out_rdy = 1'b0;

      // ---------------- reset state ----------------
      repeat (3) tick();
      chk("rst_in_rdy",  160'(in_rdy),    160'(0));
      chk("rst_out_vld", 160'(out_vld),   160'(0));
      chk("rst_mul_A",   160'(mul_A),     160'(0));
      chk("rst_pookg",   160'(mul_pookg), 160'(0));
      chk("rst_out",     160'({out_hi, out_lo, out_dbl, out_tag, out_ovf}), 160'(0));
      rst = 1'b1;
      tick();
      chk("post_rst_in_rdy", 160'(in_rdy), 160'(1));

      // ---------------- directed vectors ----------------
      out_rdy = 1'b1;
      for (int k = 0; k < 7; k++) begin
         in_A = vt[k].a; in_B = vt[k].b; in_rnd = vt[k].rnd;
         in_dbl = vt[k].dbl; in_tag = vt[k].tag; in_vld = 1'b1;
         n = 0;
         while (!in_rdy && n < 50) begin tick(); n++; end
         chk("vec_rdy", 160'(in_rdy), 160'(1));
         tick();
         in_vld = 1'b0;
         if (vt[k].dbl) begin
            chk("dbl_rdy_low", 160'(in_rdy),    160'(0));
            chk("dbl_pookg0",  160'(mul_pookg), 160'(0));
         end
         lat = 0;
         while (!out_vld && lat < 20) begin
            tick();
            lat++;
            if (vt[k].dbl && lat == 1) chk("dbl_pookg1", 160'(mul_pookg), 160'(1));
         end
         chk("vec_latency", 160'(lat),     160'(vt[k].dbl ? 4 : 3));
         chk("vec_hi",      160'(out_hi),  160'(vt[k].hi));
         chk("vec_lo",      160'(out_lo),  160'(vt[k].lo));
         chk("vec_dbl",     160'(out_dbl), 160'(vt[k].dbl));
         chk("vec_tag",     160'(out_tag), 160'(vt[k].tag));
         chk("vec_ovf",     160'(out_ovf), 160'(vt[k].ovf));
      end
      tick();
      tick();
      chk("vec_empty", 160'(out_vld), 160'(0));

      // ---------------- backpressure: 4 credits ----------------
      out_rdy = 1'b0; in_vld = 1'b1; in_dbl = 1'b0; in_rnd = 1'b0;
      in_A = 64'h4000_0000_0000_0000; in_B = 64'h4000_0000_0000_0000;
      acc0 = n_acc; pop0 = n_pop;
      for (int k = 0; k < 10; k++) begin
         in_tag = TAG_W'(n_acc - acc0);
         step();
      end
      chk("bp_accepted", 160'(n_acc - acc0), 160'(4));
      chk("bp_rdy_low",  160'(in_rdy),       160'(0));
      in_vld = 1'b0; out_rdy = 1'b1;
      for (int k = 0; k < 12; k++) step();
      chk("bp_drained", 160'(sbq.size()),   160'(0));
      chk("bp_popped",  160'(n_pop - pop0), 160'(4));
      chk("bp_idle",    160'(out_vld),      160'(0));

      // ---------------- mixed single/double stream ----------------
      for (int k = 0; k < 6; k++) begin
         opa[k] = {$urandom(), $urandom()};
         opb[k] = {$urandom(), $urandom()};
         opa[k][62:53] = 10'h1F8 + 10'($urandom_range(0, 15));
         opb[k][62:53] = 10'h1F8 + 10'($urandom_range(0, 15));
      end
      acc0 = n_acc; pop0 = n_pop; issued = 0; cyc = 0; max_out = 0;
      while ((issued < 6 || sbq.size() != 0) && cyc < 300) begin
         out_rdy = ($urandom_range(0, 1) == 1);
         if (issued < 6) begin
            in_vld = 1'b1;
            in_tag = TAG_W'(issued + 1);
            in_dbl = (issued % 2 == 1);
            in_rnd = ((issued / 2) % 2 == 1);
            in_A   = opa[issued];
            in_B   = opb[issued];
         end else begin
            in_vld = 1'b0;
         end
         prev = n_acc;
         step();
         if (n_acc != prev) issued++;
         cyc++;
      end
      in_vld = 1'b0;
      chk("mix_issued",  160'(issued),       160'(6));
      chk("mix_drained", 160'(sbq.size()),   160'(0));
      chk("mix_popped",  160'(n_pop - pop0), 160'(6));
      chk("credit_max",  160'(max_out <= DEPTH), 160'(1));

      // ---------------- reset with work in flight ----------------
      out_rdy = 1'b0; in_vld = 1'b1; in_dbl = 1'b0; in_tag = 4'hB;
      in_A = 64'h4000_0000_0000_0000; in_B = 64'h4000_0000_0000_0000;
      step();
      in_dbl = 1'b1; in_tag = 4'hC;
      step();
      in_vld = 1'b0;
      chk("pre_rst_lo_rdy",   160'(in_rdy),    160'(0));
      chk("pre_rst_lo_pookg", 160'(mul_pookg), 160'(0));
      rst = 1'b0;
      tick();
      chk("mid_rst_in_rdy",  160'(in_rdy),  160'(0));
      chk("mid_rst_out_vld", 160'(out_vld), 160'(0));
      rst = 1'b1;
      sbq.delete();
      n_acc = 0; n_pop = 0;
      tick();
      chk("after_rst_rdy", 160'(in_rdy),  160'(1));
      chk("after_rst_vld", 160'(out_vld), 160'(0));
      out_rdy = 1'b1; stale = 0;
      for (int k = 0; k < 10; k++) begin
         if (out_vld) stale++;
         step();
      end
      chk("no_stale", 160'(stale), 160'(0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fpuprod_seq.md
Name: fpuprod_seq

Overview:
- Issue and collect sequencer wrapped around the fpuprod64 multiplier stage.
- Upstream: accepts multiply requests over a valid/ready handshake and drives the multiplier operand ports.
- Double-length requests are issued twice: pookg=0 for the high half, pookg=1 for the low half.
- Downstream: collects results after the fixed multiplier latency, pairs them into hi/lo words and presents them through a backpressured output FIFO.
- The multiplier cannot stall, so a credit scheme makes sure every issued product has a reserved FIFO slot.

Parameters:
- MUL_LAT, 2: cycles from operand issue to result valid on mul_res/mul_res2.
- DEPTH, 4: output FIFO entries; also the credit limit (power of two).
- TAG_W, 4: width of the request tag.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- in_vld  in  1  request valid
- in_rdy  out  1  request accepted when in_vld & in_rdy
- in_A  in  64  operand A (sign 63, exp 62:53 bias 0x200, mant 52:0 with hidden 1)
- in_B  in  64  operand B, same format
- in_rnd  in  1  round-injection bit, passed to the multiplier
- in_dbl  in  1  1 = double-length (hi+lo) product
- in_tag  in  TAG_W  opaque tag, returned with the result
- mul_A  out  64  multiplier operand A (registered)
- mul_B  out  64  multiplier operand B (registered)
- mul_rnd  out  1  multiplier rnd (registered)
- mul_pookg  out  1  0 = high half, 1 = low half (registered)
- mul_res  in  64  multiplier high result
- mul_res2  in  64  multiplier low result
- out_vld  out  1  result valid
- out_rdy  in  1  result consumed when out_vld & out_rdy
- out_hi  out  64  high product word
- out_lo  out  64  low product word; 0 when out_dbl=0
- out_dbl  out  1  echo of in_dbl
- out_tag  out  TAG_W  echo of in_tag
- out_ovf  out  1  &out_hi[62:53] (saturated exponent)

Behaviour:
- Reset (rst=0 at a clk edge):
  - All outputs 0 (in_rdy=0 during reset).
  - FSM to IDLE; FIFO empty; credits=0; issue-valid shift register cleared.
  - In-flight multiplier results are discarded, including on reset mid-operation.
- FSM states:
  - IDLE: in_rdy = (credits < DEPTH).
  - On accept with in_dbl=0: load mul_* from the inputs with mul_pookg=0, mark one slot issued (kind SGL), stay in IDLE.
  - On accept with in_dbl=1: load mul_* with pookg=0, mark slot HI, go to LO.
  - LO: in_rdy=0; hold mul_A/B/rnd, set mul_pookg=1, mark slot LO, return to IDLE.
  - Double throughput is one request per 2 cycles; single throughput is one per cycle.
- Issue timing:
  - A slot marked at the edge ending cycle t-1 drives the multiplier during cycle t.
  - Its result is sampled from mul_res/mul_res2 at the edge ending cycle t+MUL_LAT.
  - A MUL_LAT-deep shift register carries {valid, kind, tag} alongside the multiplier.
- Result capture:
  - SGL: push {hi=mul_res, lo=0}.
  - HI: latch mul_res into a pending-hi register; no push.
  - LO: push {hi=pending, lo=mul_res2}.
  - mul_res[52:0] is undriven when pookg=1, so it is never sampled for LO slots.
- Credits:
  - +1 on accept, -1 on FIFO pop; a simultaneous accept and pop leaves credits unchanged.
  - A double request uses one credit.
  - The invariant credits = in-flight requests + FIFO count <= DEPTH guarantees a push never finds the FIFO full.
  - in_rdy depends only on registered state, never combinationally on out_rdy.
- FIFO:
  - out_* is taken from the FIFO head; push and pop are allowed in the same cycle, including when full or empty.
  - Results are delivered in order.
- No flush input; only reset clears in-flight work.

Decomposition:
- Shared package fpu_pkg:
  - FP64 field constants: SIGN=63, EXP_HI=62, EXP_LO=53, MANT_W=53, BIAS=10'h200.
  - Slot-kind enum {SGL, HI, LO}.
  - Typedef of the FIFO entry struct.
- One sub-module: fpuprod_fifo, a DEPTH×(128+1+TAG_W) synchronous FIFO with count output.
- fpuprod64 is instantiated by the parent, not inside this block.

Test Plan:
- Single product, 1.0×1.0: in_A=in_B=64'h4000_0000_0000_0000, in_dbl=0, tag=3 with multiplier model attached -> out_hi=64'h4000_0000_0000_0000, out_lo=0, tag=3, out_vld 3 cycles after accept.
- Double product, same operands with in_dbl=1 -> in_rdy low for 1 cycle; mul_pookg 0 then 1; single output out_hi=64'h4000_0000_0000_0000, out_lo=64'h3960_0000_0000_0000.
- Sign: in_A=64'hC000_0000_0000_0000, in_B=1.0 -> out_hi=64'hC000_0000_0000_0000.
- Backpressure: out_rdy=0 with 10 single requests offered -> exactly 4 accepted, in_rdy=0 after that; release out_rdy -> tags delivered in order, no loss or duplication.
- Mixed stream: tags 1..6 alternating single/double with random out_rdy -> order and hi/lo pairing match the model; credits never exceed 4.
- Reset while a double is in state LO with 2 results in flight -> after reset out_vld=0, in_rdy=1 next cycle, no stale result ever emitted.
